fifo_stream_ctrl: RTL and testbench
===================================

Name: fifo_stream_ctrl

Overview:
Flow controller that sequences the 16-bit-in / 24-bit-out sample FIFO between a host writer and a sample-rate consumer, such as the codec serializer.
- Host side: owns the FIFO's clear, write-enable and pop signals; tracks occupancy itself in bits; never overfills the FIFO.
- Consumer side: on each sample tick it returns the 24-bit head word and pops it.
- Priming: it holds the consumer off until the FIFO is primed.
- Errors: it reports underruns and raises a refill request when low.

Parameters:
BUF_SIZE, 512, FIFO capacity in bits
WR_BITS, 16, bits per FIFO write
RD_BITS, 24, bits per FIFO pop
PRIME_LEVEL, 384, level in bits at which PRIME exits to RUN
LW_MARK, 128, refill_req asserts while level < LW_MARK
AUTO_REPRIME, 1, 1: an underrun returns to PRIME; 0: stay in RUN

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  stream enable; low forces IDLE
host_valid  in  1  host_data valid
host_data  in  WR_BITS  write word
host_ready  out  1  write accepted when host_valid && host_ready at a clk edge
sample_tick  in  1  one-cycle consumer request
sample_out  out  RD_BITS  returned sample
sample_valid  out  1  one-cycle pulse; sample_out valid
fifo_clear  out  1  to FIFO clear
fifo_we  out  1  to FIFO we
fifo_din  out  WR_BITS  to FIFO din
fifo_pop  out  1  to FIFO pop_front
fifo_dout  in  RD_BITS  from FIFO dout (registered head word)
refill_req  out  1  level below LW_MARK in PRIME/RUN
underrun_count  out  16  saturating underrun counter
state  out  2  0 IDLE, 1 PRIME, 2 RUN

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, fifo_clear=1.
  - All other outputs 0; level=0, underrun_count=0, no pending tick.
- All outputs are registered.
- level: width $clog2(BUF_SIZE)+1.
  - +WR_BITS per accepted write, −RD_BITS per issued pop.
  - Write and pop in the same cycle: net −8.
  - Never exceeds BUF_SIZE and never goes negative.
- avail: level minus writes accepted in the last 3 cycles (3-stage accept shift register). Covers the FIFO write and dout register latency.
- Write path:
  - Accept at edge T gives fifo_we=1 and fifo_din=host_data during cycle T+1.
  - host_ready = (state is PRIME or RUN) && level ≤ BUF_SIZE−WR_BITS, evaluated with this cycle's accept included.
- IDLE:
  - fifo_clear=1, host_ready=0, level=0; ticks are ignored.
  - enable=1 moves to PRIME, with fifo_clear=0 from the next cycle.
- PRIME:
  - Writes are accepted; no pops; ticks are ignored with no sample_valid.
  - Moves to RUN on the edge where level ≥ PRIME_LEVEL.
- RUN, tick sampled at edge T with avail ≥ RD_BITS:
  - sample_out=fifo_dout as sampled at T, with sample_valid=1 in cycle T+1.
  - fifo_pop=1 in cycle T+1 only.
  - level −= RD_BITS at edge T+1.
- Pop spacing:
  - fifo_pop is never high in two consecutive cycles.
  - A 3-cycle cooldown follows each serviced tick, so the next service is at edge T+4 at the earliest.
  - A tick during cooldown is held as one pending tick and serviced when the cooldown ends.
  - A further tick while one is pending is dropped silently.
- Underrun (tick serviced with avail < RD_BITS):
  - sample_out=0, sample_valid=1, no pop; underrun_count+1, saturating at 0xFFFF.
  - AUTO_REPRIME=1 moves to PRIME; the level is kept.
- refill_req: registered; = (state≠IDLE) && level < LW_MARK.
- enable=0 in any state:
  - IDLE on the next edge; fifo_clear=1; level=0.
  - The pending tick is discarded; an in-flight fifo_we/fifo_pop is cancelled.
  - underrun_count is retained; only reset_n clears it.
- Reset mid-operation: immediate return to the reset values above, asynchronously.

Test Plan:
- Reset, enable=1, 24 back-to-back host writes (0x0001..0x0018) → state=RUN on the edge after the 24th accept, level=384, fifo_we pulsed 24 times, fifo_clear=0.
- Continue writing in RUN → 8 further accepts (level=512); host_ready=0 and 33rd word not accepted; no fifo_we for it.
- Prime to 384, then ticks every 4 cycles, no writes → 16 samples with sample_valid and fifo_pop each one cycle; 17th tick gives sample_out=0, underrun_count=1, state=PRIME. refill_req=1 after 11th pop (level=120).
- Ticks at T and T+1 → second tick serviced at T+4; ticks at T, T+1, T+2 → exactly 2 services, no back-to-back fifo_pop.
- Write accept and tick service on same edge at level=384 → level=376; a tick 1 cycle after a write that lifted level from 16 to 32 → underrun (avail=16).
- enable=0 mid-RUN at level 200 → IDLE next edge, fifo_clear=1, level=0, host_ready=0, underrun_count unchanged. reset_n=0 mid-write → all outputs 0 and fifo_clear=1 without waiting for clk.

Source files
------------

// File: rtl/fifo_stream_ctrl_if.sv
// fifo_stream_ctrl_if: host, consumer, FIFO and status signals of the stream controller.
interface fifo_stream_ctrl_if #(
  parameter int WR_BITS = 16,
  parameter int RD_BITS = 24
);
  logic               enable;
  logic               host_valid;
  logic [WR_BITS-1:0] host_data;
  logic               host_ready;
  logic               sample_tick;
  logic [RD_BITS-1:0] sample_out;
  logic               sample_valid;
  logic               fifo_clear;
  logic               fifo_we;
  logic [WR_BITS-1:0] fifo_din;
  logic               fifo_pop;
  logic [RD_BITS-1:0] fifo_dout;
  logic               refill_req;
  logic [15:0]        underrun_count;
  logic [1:0]         state;
  modport slave (
    input  enable, host_valid, host_data, sample_tick, fifo_dout,
    output host_ready, sample_out, sample_valid, fifo_clear, fifo_we, fifo_din,
           fifo_pop, refill_req, underrun_count, state
  );
  modport master (
    output enable, host_valid, host_data, sample_tick, fifo_dout,
    input  host_ready, sample_out, sample_valid, fifo_clear, fifo_we, fifo_din,
           fifo_pop, refill_req, underrun_count, state
  );
endinterface

// File: rtl/fifo_stream_ctrl.sv
// fifo_stream_ctrl: primes a 16-in/24-out sample FIFO from the host and serves paced consumer ticks.
module fifo_stream_ctrl #(
  parameter int BUF_SIZE     = 512,
  parameter int WR_BITS      = 16,
  parameter int RD_BITS      = 24,
  parameter int PRIME_LEVEL  = 384,
  parameter int LW_MARK      = 128,
  parameter bit AUTO_REPRIME = 1'b1
) (
  input logic          clk,
  input logic          reset_n,
  fifo_stream_ctrl_if.slave bus
);
  localparam int LW = $clog2(BUF_SIZE) + 1;
  localparam int W  = LW + 1;
  localparam logic [W-1:0] K_WR    = W'(WR_BITS);
  localparam logic [W-1:0] K_RD    = W'(RD_BITS);
  localparam logic [W-1:0] K_TOP   = W'(BUF_SIZE - WR_BITS);
  localparam logic [W-1:0] K_PRIME = W'(PRIME_LEVEL);
  localparam logic [W-1:0] K_LW    = W'(LW_MARK);
  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;
  state_t               r_state, w_state_nx;
  logic [LW-1:0]        r_level;
  logic [2:0]           r_acc, w_acc_nx;
  logic [1:0]           r_cool, w_cool_nx;
  logic                 r_pend, w_pend_nx;
  logic                 r_host_ready, w_host_ready_nx;
  logic [RD_BITS-1:0]   r_sample_out, w_sample_out_nx;
  logic                 r_sample_valid;
  logic                 r_fifo_clear;
  logic                 r_fifo_we;
  logic [WR_BITS-1:0]   r_fifo_din, w_fifo_din_nx;
  logic                 r_fifo_pop;
  logic                 r_refill, w_refill_nx;
  logic [15:0]          r_urun, w_urun_nx;
  logic [W-1:0]         w_lvl, w_lvl_nx, w_recent;
  logic                 w_acc, w_service, w_avail_ok, w_pop, w_under, w_idle_nx;
  // Writes accepted in the last 3 cycles are not yet visible at the FIFO head.
  always_comb begin
    w_lvl           = {1'b0, r_level};
    w_recent        = (W'(r_acc[0]) + W'(r_acc[1]) + W'(r_acc[2])) * K_WR;
    w_avail_ok      = w_lvl >= w_recent + K_RD;
    w_acc           = bus.host_valid && r_host_ready && bus.enable;
    w_service       = bus.enable && r_state == RUN && r_cool == 2'd0 && (bus.sample_tick || r_pend);
    w_pop           = w_service && w_avail_ok;
    w_under         = w_service && !w_avail_ok;
    w_state_nx      = !bus.enable ? IDLE :
                      r_state == IDLE ? PRIME :
                      r_state == PRIME ? (w_lvl >= K_PRIME ? RUN : PRIME) :
                      (w_under && AUTO_REPRIME) ? PRIME : RUN;
    w_idle_nx       = w_state_nx == IDLE;
    w_lvl_nx        = w_idle_nx ? '0 : w_lvl + (w_acc ? K_WR : '0) - (r_fifo_pop ? K_RD : '0);
    w_host_ready_nx = !w_idle_nx && w_lvl_nx <= K_TOP;
    w_refill_nx     = !w_idle_nx && w_lvl_nx < K_LW;
    w_acc_nx        = w_idle_nx ? 3'd0 : {r_acc[1:0], w_acc};
    w_cool_nx       = w_service ? 2'd3 : (r_cool != 2'd0 ? r_cool - 2'd1 : 2'd0);
    w_pend_nx       = bus.enable && r_state == RUN && !w_service && (r_pend || bus.sample_tick);
    w_sample_out_nx = w_pop ? bus.fifo_dout : (w_under ? '0 : r_sample_out);
    w_urun_nx       = (w_under && r_urun != 16'hFFFF) ? r_urun + 16'd1 : r_urun;
    w_fifo_din_nx   = w_acc ? bus.host_data : r_fifo_din;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_level        <= '0;
      r_acc          <= '0;
      r_cool         <= '0;
      r_pend         <= 1'b0;
      r_host_ready   <= 1'b0;
      r_sample_out   <= '0;
      r_sample_valid <= 1'b0;
      r_fifo_clear   <= 1'b1;
      r_fifo_we      <= 1'b0;
      r_fifo_din     <= '0;
      r_fifo_pop     <= 1'b0;
      r_refill       <= 1'b0;
      r_urun         <= '0;
    end else begin
      r_state        <= w_state_nx;
      r_level        <= w_lvl_nx[LW-1:0];
      r_acc          <= w_acc_nx;
      r_cool         <= w_cool_nx;
      r_pend         <= w_pend_nx;
      r_host_ready   <= w_host_ready_nx;
      r_sample_out   <= w_sample_out_nx;
      r_sample_valid <= w_service;
      r_fifo_clear   <= w_idle_nx;
      r_fifo_we      <= w_acc;
      r_fifo_din     <= w_fifo_din_nx;
      r_fifo_pop     <= w_pop;
      r_refill       <= w_refill_nx;
      r_urun         <= w_urun_nx;
    end
  end
  assign bus.state          = r_state;
  assign bus.host_ready     = r_host_ready;
  assign bus.sample_out     = r_sample_out;
  assign bus.sample_valid   = r_sample_valid;
  assign bus.fifo_clear     = r_fifo_clear;
  assign bus.fifo_we        = r_fifo_we;
  assign bus.fifo_din       = r_fifo_din;
  assign bus.fifo_pop       = r_fifo_pop;
  assign bus.refill_req     = r_refill;
  assign bus.underrun_count = r_urun;
endmodule

// File: tb/tb_fifo_stream_ctrl.sv
// tb_fifo_stream_ctrl: directed stimulus with hand-computed expectations for fifo_stream_ctrl.
module tb_fifo_stream_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   cnt;
  logic prev;
  fifo_stream_ctrl_if bus ();
  fifo_stream_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic prime(input int n);
    bus.enable = 1'b0;
    step;
    bus.enable = 1'b1;
    step;
    for (int i = 0; i < n; i++) begin
      bus.host_valid = 1'b1;
      bus.host_data  = 16'(i + 1);
      step;
    end
    bus.host_valid = 1'b0;
    step; step; step; step;
  endtask
  task automatic tick4(input string tag, input logic [23:0] d, input logic [23:0] eo, input logic ep);
    bus.fifo_dout   = d;
    bus.sample_tick = 1'b1;
    step;
    bus.sample_tick = 1'b0;
    chk({tag, "_valid"}, 32'(bus.sample_valid), 32'd1);
    chk({tag, "_out"}, 32'(bus.sample_out), 32'(eo));
    chk({tag, "_pop"}, 32'(bus.fifo_pop), 32'(ep));
    step;
    chk({tag, "_pop_next"}, 32'(bus.fifo_pop), 32'd0);
    step; step;
  endtask
  initial begin
    reset_n = 1'b1;
    bus.enable = 1'b0; bus.host_valid = 1'b0; bus.host_data = '0;
    bus.sample_tick = 1'b0; bus.fifo_dout = '0;
    #2 reset_n = 1'b0;
    step; step;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_clear", 32'(bus.fifo_clear), 32'd1);
    chk("rst_ready", 32'(bus.host_ready), 32'd0);
    chk("rst_we", 32'(bus.fifo_we), 32'd0);
    chk("rst_refill", 32'(bus.refill_req), 32'd0);
    chk("rst_urun", 32'(bus.underrun_count), 32'd0);
    reset_n = 1'b1;
    bus.enable = 1'b1;
    step;
    chk("prime_state", 32'(bus.state), 32'd1);
    chk("prime_clear", 32'(bus.fifo_clear), 32'd0);
    chk("prime_ready", 32'(bus.host_ready), 32'd1);
    cnt = 0;
    for (int i = 1; i <= 24; i++) begin
      bus.host_valid = 1'b1;
      bus.host_data  = 16'(i);
      step;
      if (bus.fifo_we) cnt++;
      chk($sformatf("wr%0d_din", i), 32'(bus.fifo_din), 32'(i));
    end
    bus.host_valid = 1'b0;
    chk("we_count24", 32'(cnt), 32'd24);
    chk("lvl384", 32'(dut.r_level), 32'd384);
    chk("still_prime", 32'(bus.state), 32'd1);
    step;
    chk("run_state", 32'(bus.state), 32'd2);
    chk("run_we_idle", 32'(bus.fifo_we), 32'd0);
    for (int i = 25; i <= 32; i++) begin
      bus.host_valid = 1'b1;
      bus.host_data  = 16'(i);
      step;
      chk($sformatf("wr%0d_we", i), 32'(bus.fifo_we), 32'd1);
    end
    chk("lvl512", 32'(dut.r_level), 32'd512);
    chk("full_ready", 32'(bus.host_ready), 32'd0);
    bus.host_data = 16'd33;
    step;
    bus.host_valid = 1'b0;
    chk("full_no_we", 32'(bus.fifo_we), 32'd0);
    chk("full_lvl", 32'(dut.r_level), 32'd512);
    prime(24);
    chk("p2_state", 32'(bus.state), 32'd2);
    for (int k = 0; k < 16; k++) begin
      tick4($sformatf("s%0d", k), 24'h100000 + 24'(k), 24'h100000 + 24'(k), 1'b1);
      chk($sformatf("s%0d_refill", k), 32'(bus.refill_req), (k >= 10) ? 32'd1 : 32'd0);
    end
    chk("drain_lvl", 32'(dut.r_level), 32'd0);
    bus.fifo_dout   = 24'h777777;
    bus.sample_tick = 1'b1;
    step;
    bus.sample_tick = 1'b0;
    chk("ur_valid", 32'(bus.sample_valid), 32'd1);
    chk("ur_out", 32'(bus.sample_out), 32'd0);
    chk("ur_pop", 32'(bus.fifo_pop), 32'd0);
    chk("ur_count", 32'(bus.underrun_count), 32'd1);
    chk("ur_state", 32'(bus.state), 32'd1);
    prime(24);
    bus.sample_tick = 1'b1;
    step;
    chk("pair_t0_pop", 32'(bus.fifo_pop), 32'd1);
    step;
    bus.sample_tick = 1'b0;
    chk("pair_t1_pop", 32'(bus.fifo_pop), 32'd0);
    step;
    chk("pair_t2_pop", 32'(bus.fifo_pop), 32'd0);
    step;
    chk("pair_t3_pop", 32'(bus.fifo_pop), 32'd0);
    step;
    chk("pair_t4_pop", 32'(bus.fifo_pop), 32'd1);
    chk("pair_t4_valid", 32'(bus.sample_valid), 32'd1);
    step;
    chk("pair_t5_pop", 32'(bus.fifo_pop), 32'd0);
    step; step;
    cnt  = 0;
    prev = 1'b0;
    for (int i = 0; i < 11; i++) begin
      bus.sample_tick = (i < 3);
      step;
      if (bus.fifo_pop) cnt++;
      if (prev && bus.fifo_pop) chk("b2b_pop", 32'd1, 32'd0);
      prev = bus.fifo_pop;
    end
    bus.sample_tick = 1'b0;
    chk("triple_services", 32'(cnt), 32'd2);
    chk("triple_lvl", 32'(dut.r_level), 32'd288);
    prime(24);
    bus.host_valid  = 1'b1;
    bus.host_data   = 16'h0055;
    bus.sample_tick = 1'b1;
    bus.fifo_dout   = 24'hABCDEF;
    step;
    bus.host_valid  = 1'b0;
    bus.sample_tick = 1'b0;
    chk("same_we", 32'(bus.fifo_we), 32'd1);
    chk("same_pop", 32'(bus.fifo_pop), 32'd1);
    chk("same_out", 32'(bus.sample_out), 32'hABCDEF);
    chk("same_lvl_a", 32'(dut.r_level), 32'd400);
    step;
    chk("same_lvl_b", 32'(dut.r_level), 32'd376);
    prime(25);
    for (int k = 0; k < 16; k++) tick4($sformatf("a%0d", k), 24'h200000 + 24'(k), 24'h200000 + 24'(k), 1'b1);
    chk("avail_lvl16", 32'(dut.r_level), 32'd16);
    bus.host_valid = 1'b1;
    bus.host_data  = 16'h00AA;
    step;
    bus.host_valid  = 1'b0;
    chk("avail_lvl32", 32'(dut.r_level), 32'd32);
    bus.sample_tick = 1'b1;
    step;
    bus.sample_tick = 1'b0;
    chk("avail_ur_valid", 32'(bus.sample_valid), 32'd1);
    chk("avail_ur_out", 32'(bus.sample_out), 32'd0);
    chk("avail_ur_pop", 32'(bus.fifo_pop), 32'd0);
    chk("avail_ur_count", 32'(bus.underrun_count), 32'd2);
    chk("avail_ur_state", 32'(bus.state), 32'd1);
    prime(26);
    for (int k = 0; k < 9; k++) tick4($sformatf("e%0d", k), 24'h300000 + 24'(k), 24'h300000 + 24'(k), 1'b1);
    chk("en_lvl200", 32'(dut.r_level), 32'd200);
    chk("en_run", 32'(bus.state), 32'd2);
    bus.enable      = 1'b0;
    bus.host_valid  = 1'b1;
    bus.sample_tick = 1'b1;
    step;
    bus.host_valid  = 1'b0;
    bus.sample_tick = 1'b0;
    chk("dis_state", 32'(bus.state), 32'd0);
    chk("dis_clear", 32'(bus.fifo_clear), 32'd1);
    chk("dis_lvl", 32'(dut.r_level), 32'd0);
    chk("dis_ready", 32'(bus.host_ready), 32'd0);
    chk("dis_we", 32'(bus.fifo_we), 32'd0);
    chk("dis_pop", 32'(bus.fifo_pop), 32'd0);
    chk("dis_valid", 32'(bus.sample_valid), 32'd0);
    chk("dis_urun", 32'(bus.underrun_count), 32'd2);
    bus.enable = 1'b1;
    step;
    bus.host_valid = 1'b1;
    bus.host_data  = 16'h1234;
    step; step;
    chk("mid_we", 32'(bus.fifo_we), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_state", 32'(bus.state), 32'd0);
    chk("arst_clear", 32'(bus.fifo_clear), 32'd1);
    chk("arst_we", 32'(bus.fifo_we), 32'd0);
    chk("arst_din", 32'(bus.fifo_din), 32'd0);
    chk("arst_ready", 32'(bus.host_ready), 32'd0);
    chk("arst_refill", 32'(bus.refill_req), 32'd0);
    chk("arst_urun", 32'(bus.underrun_count), 32'd0);
    bus.host_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
